// File: rtl/lut_func_eval.sv
// Programmable N-input Boolean function evaluator: truth-table lookup behind a
// 2-stage registered pipeline, with a serial shadow-table loader that never stalls lookup.
module lut_func_eval #(
    parameter int unsigned           N_IN       = 5,
    parameter logic [(2**N_IN)-1:0]  DEFAULT_TT = 32'hF1F1F10E
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in,
    output logic            out_valid,
    output logic            out,
    input  logic            cfg_start,
    input  logic            cfg_bit_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done
);

    localparam int unsigned      TT_W     = 2**N_IN;
    localparam int unsigned      CNT_W    = N_IN + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TT_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TT_W-1:0]  shadow_q, shadow_d;
    logic [TT_W-1:0]  active_tt_q, active_tt_d;

    logic             s1_v_q, s1_v_d;
    logic [N_IN-1:0]  s1_in_q, s1_in_d;
    logic             out_valid_q, out_valid_d;
    logic             out_q, out_d;

    // Config loader: shifts bits MSB-first into the shadow, swaps it in on COMMIT.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        active_tt_d = active_tt_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_bit_valid) begin
                    shadow_d = {shadow_q[TT_W-2:0], cfg_bit};
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                active_tt_d = shadow_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lookup reads the table as registered at the output edge, so a COMMIT-exit
    // edge still evaluates with the old table.
    always_comb begin
        s1_v_d      = in_valid;
        s1_in_d     = in;
        out_valid_d = s1_v_q;
        out_d       = out_q;
        if (s1_v_q) begin
            out_d = active_tt_q[s1_in_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            active_tt_q <= DEFAULT_TT;
            s1_v_q      <= 1'b0;
            s1_in_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_tt_q <= active_tt_d;
            s1_v_q      <= s1_v_d;
            s1_in_q     <= s1_in_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    // Shadow contents are meaningless until a full load completes, so no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign cfg_busy  = (state_q != IDLE);
    assign cfg_done  = (state_q == COMMIT);

endmodule

// File: tb/tb_lut_func_eval.sv
// Scoreboard bench for lut_func_eval: directed stimulus pushes expected results,
// per-instance monitors pop and compare whenever out_valid is presented.
module tb_lut_func_eval;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0, cfg_start = 1'b0, cfg_bit_valid = 1'b0, cfg_bit = 1'b0;
    logic [4:0] in_v = '0;
    logic       out_valid, out_b, cfg_busy, cfg_done;

    logic       in_valid2 = 1'b0, cfg_start2 = 1'b0, cfg_bit_valid2 = 1'b0, cfg_bit2 = 1'b0;
    logic [2:0] in_v2 = '0;
    logic       out_valid2, out_b2, cfg_busy2, cfg_done2;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_cnt2 = 0;
    logic exp_q[$];
    logic exp2_q[$];
    logic mon_e, mon_e2;

    always #5 clk = ~clk;

    lut_func_eval dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_v),
        .out_valid(out_valid), .out(out_b),
        .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid), .cfg_bit(cfg_bit),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done)
    );

    lut_func_eval #(.N_IN(3), .DEFAULT_TT(8'h96)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in(in_v2),
        .out_valid(out_valid2), .out(out_b2),
        .cfg_start(cfg_start2), .cfg_bit_valid(cfg_bit_valid2), .cfg_bit(cfg_bit2),
        .cfg_busy(cfg_busy2), .cfg_done(cfg_done2)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out: unexpected out_valid, got out=%b want no result at %0t", out_b, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out", out_b, mon_e);
            end
        end
        if (cfg_done === 1'b1) done_cnt++;
    end

    always @(negedge clk) begin
        if (out_valid2 === 1'b1) begin
            if (exp2_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out2: unexpected out_valid, got out=%b want no result at %0t", out_b2, $time);
            end else begin
                mon_e2 = exp2_q.pop_front();
                chk("out2", out_b2, mon_e2);
            end
        end
        if (cfg_done2 === 1'b1) done_cnt2++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid       = 1'b0;
        cfg_start      = 1'b0;
        cfg_bit_valid  = 1'b0;
        cfg_bit        = 1'b0;
        in_valid2      = 1'b0;
        cfg_start2     = 1'b0;
        cfg_bit_valid2 = 1'b0;
        cfg_bit2       = 1'b0;
    endtask

    task automatic ev(input logic [4:0] x, input logic e);
        in_valid = 1'b1;
        in_v     = x;
        exp_q.push_back(e);
    endtask

    task automatic ev2(input logic [2:0] x, input logic e);
        in_valid2 = 1'b1;
        in_v2     = x;
        exp2_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (exp_q.size() != 0 || exp2_q.size() != 0); i++) tick();
        chk("drain", (exp_q.size() == 0 && exp2_q.size() == 0), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] def_tt, old_tt, new_tt, tt4;
        logic [7:0]  tt2;
        int          d0;
        def_tt = 32'hF1F1F10E;

        // Reset state
        rst = 1'b1;
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out", out_b, 1'b0);
        chk("rst_busy", cfg_busy, 1'b0);
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_out_valid2", out_valid2, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // 1: back-to-back sweep with default table, plus latency check
        for (int i = 0; i < 32; i++) begin
            ev(5'(i), def_tt[i]);
            tick();
            if (i == 0) chk("lat_cycle1", out_valid, 1'b0);
            if (i == 1) chk("lat_cycle2", out_valid, 1'b1);
        end
        ev(5'd0, 1'b0); tick();
        ev(5'd1, 1'b1); tick();
        ev(5'd3, 1'b1); tick();
        ev(5'd4, 1'b0); tick();
        ev(5'd8, 1'b1); tick();
        ev(5'd9, 1'b0); tick();
        ev(5'd31, 1'b1); tick();
        drain();

        // 2: contiguous load of 80000001
        old_tt = 32'h80000001;
        d0 = done_cnt;
        cfg_start = 1'b1;
        tick();
        chk("t2_busy_load", cfg_busy, 1'b1);
        for (int j = 0; j < 32; j++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = old_tt[31-j];
            tick();
            if (j == 30) chk("t2_no_early_done", cfg_done, 1'b0);
        end
        chk("t2_done_pulse", cfg_done, 1'b1);
        chk("t2_busy_commit", cfg_busy, 1'b1);
        tick();
        chk("t2_done_clear", cfg_done, 1'b0);
        chk("t2_busy_clear", cfg_busy, 1'b0);
        chk("t2_one_done", (done_cnt - d0) == 1, 1'b1);
        ev(5'd0, 1'b1); tick();
        ev(5'd31, 1'b1); tick();
        ev(5'd5, 1'b0); tick();
        drain();

        // 3: evaluate every cycle during a load of the complement table
        new_tt = 32'h7FFFFFFE;
        cfg_start = 1'b1;
        ev(5'd0, old_tt[0]);
        tick();
        for (int j = 0; j < 32; j++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = new_tt[31-j];
            ev(5'((j * 7) % 32), old_tt[(j * 7) % 32]);
            tick();
            chk("t3_no_bubble", out_valid, 1'b1);
        end
        for (int j = 0; j < 8; j++) begin
            ev(5'((j * 5) % 32), new_tt[(j * 5) % 32]);
            tick();
            chk("t3_no_bubble", out_valid, 1'b1);
        end
        drain();

        // 4: partial load, restart, full 0000FFFF load with gaps
        tt4 = 32'h0000FFFF;
        d0 = done_cnt;
        cfg_start = 1'b1;
        tick();
        for (int j = 0; j < 10; j++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = 1'b1;
            tick();
        end
        cfg_start     = 1'b1;
        cfg_bit_valid = 1'b1;
        cfg_bit       = 1'b1;
        tick();
        chk("t4_busy_restart", cfg_busy, 1'b1);
        for (int j = 0; j < 32; j++) begin
            if ($urandom_range(0, 2) == 0) tick();
            cfg_bit_valid = 1'b1;
            cfg_bit       = tt4[31-j];
            tick();
        end
        tick();
        tick();
        chk("t4_one_done", (done_cnt - d0) == 1, 1'b1);
        ev(5'd15, 1'b1); tick();
        ev(5'd16, 1'b0); tick();
        ev(5'd0, 1'b1); tick();
        ev(5'd31, 1'b0); tick();
        drain();

        // 5: reset mid-load restores default and kills in-flight sample
        d0 = done_cnt;
        cfg_start = 1'b1;
        tick();
        for (int j = 0; j < 20; j++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_v     = 5'd9;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", cfg_busy, 1'b0);
        chk("t5_out_valid", out_valid, 1'b0);
        for (int j = 0; j < 40; j++) tick();
        chk("t5_no_done", (done_cnt - d0) == 0, 1'b1);
        ev(5'd1, 1'b1); tick();
        ev(5'd16, 1'b1); tick();
        ev(5'd4, 1'b0); tick();
        drain();

        // 6: 3-input instance, XOR default then reload 01
        ev2(3'd7, 1'b1); tick();
        ev2(3'd6, 1'b0); tick();
        ev2(3'd1, 1'b1); tick();
        drain();
        tt2 = 8'h01;
        d0 = done_cnt2;
        cfg_start2 = 1'b1;
        tick();
        for (int j = 0; j < 8; j++) begin
            cfg_bit_valid2 = 1'b1;
            cfg_bit2       = tt2[7-j];
            tick();
        end
        chk("t6_done_pulse", cfg_done2, 1'b1);
        tick();
        chk("t6_busy_clear", cfg_busy2, 1'b0);
        chk("t6_one_done", (done_cnt2 - d0) == 1, 1'b1);
        for (int x = 0; x < 8; x++) begin
            ev2(3'(x), (x == 0) ? 1'b1 : 1'b0);
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
